// File: rtl/tinyalu_pkg.sv
// -----------------------------------------------------------------------------
// tinyalu_pkg
//   Shared types for the ALU command sequencer:
//     operation_t  - 3-bit ALU operation code carried with every command
//     seq_state_t  - sequencer FSM states
//   decode_op() folds the unused codes (101, 110) onto no_op so the rest of the
//   design only ever sees legal operation_t values.
// -----------------------------------------------------------------------------
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BUSY = 3'd1,
    NOP  = 3'd2,
    RST  = 3'd3,
    RESP = 3'd4
  } seq_state_t;

  // Map a raw command code onto operation_t; unused codes behave as no_op.
  function automatic operation_t decode_op(input logic [2:0] code);
    operation_t op_v;
    case (code)
      3'b001:  op_v = add_op;
      3'b010:  op_v = and_op;
      3'b011:  op_v = xor_op;
      3'b100:  op_v = mul_op;
      3'b111:  op_v = rst_op;
      default: op_v = no_op;
    endcase
    return op_v;
  endfunction

  // True for operations that run on the ALU and wait for done.
  function automatic logic is_alu_op(input operation_t op_v);
    return (op_v == add_op) || (op_v == and_op) ||
           (op_v == xor_op) || (op_v == mul_op);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
//   Order-preserving command queue of DEPTH entries (DEPTH a power of two).
//   Each entry holds {op, a, b}. The head entry is presented combinationally so
//   the sequencer can load it in the same edge that pops it.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   push, push_a/b/op       write request and entry fields
//   ready                   high while count < DEPTH (no pop bypass)
//   pop                     remove head entry (ignored when empty)
//   head_a, head_b, head_op current head entry
//   count                   occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_a,
  input  logic [WIDTH-1:0]         push_b,
  input  logic [2:0]               push_op,
  output logic                     ready,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_a,
  output logic [WIDTH-1:0]         head_b,
  output logic [2:0]               head_op,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int EW    = 2 * WIDTH + 3;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign ready   = (count_q < CNT_W'(DEPTH));
  assign push_ok = push && ready;
  assign pop_ok  = pop && (count_q != '0);

  assign {head_op, head_a, head_b} = mem_q[rd_ptr_q];
  assign count = count_q;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {push_op, push_a, push_b};
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//   Queues ALU commands and issues them one at a time to a start/done ALU,
//   returning one response per command over a valid/ready handshake.
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_a/b/op    command input (queued in alu_cmd_fifo)
//   A, B, op, start, alu_rst_n         registered drive to the ALU
//   done, result                       ALU completion, sampled only in BUSY
//   rsp_valid/rsp_ready                response handshake
//   rsp_result, rsp_op, rsp_err        response payload (err = ALU timeout)
//   fifo_count                         current queue occupancy
//
// Command flow
//   ALU ops (add/and/xor/mul): start held high until done or TIMEOUT edges.
//   no_op (and unused codes):  start pulsed for one cycle, result 0.
//   rst_op:                    alu_rst_n driven low for two cycles, result 0.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
  import tinyalu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WIDTH-1:0]        cmd_a,
  input  logic [WIDTH-1:0]        cmd_b,
  input  logic [2:0]              cmd_op,
  output logic [WIDTH-1:0]        A,
  output logic [WIDTH-1:0]        B,
  output logic [2:0]              op,
  output logic                    start,
  input  logic                    done,
  input  logic [2*WIDTH-1:0]      result,
  output logic                    alu_rst_n,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_result,
  output logic [2:0]              rsp_op,
  output logic                    rsp_err,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  // Timer covers 0..TIMEOUT-1 in BUSY and 0..1 in RST.
  localparam int TW = $clog2(TIMEOUT + 1);

  // Queue
  logic             fifo_push;
  logic             fifo_pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [2:0]       head_op;
  operation_t       head_op_norm;

  // Sequencer state and registered outputs
  seq_state_t         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  operation_t         op_q, op_d;
  logic               start_q, start_d;
  logic               alu_rst_n_q, alu_rst_n_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0] rsp_result_q, rsp_result_d;
  operation_t         rsp_op_q, rsp_op_d;
  logic               rsp_err_q, rsp_err_d;
  logic [TW-1:0]      timer_q, timer_d;

  assign fifo_push    = cmd_valid && cmd_ready;
  assign head_op_norm = decode_op(head_op);

  alu_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .push_a  (cmd_a),
    .push_b  (cmd_b),
    .push_op (cmd_op),
    .ready   (cmd_ready),
    .pop     (fifo_pop),
    .head_a  (head_a),
    .head_b  (head_b),
    .head_op (head_op),
    .count   (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    start_d      = start_q;
    alu_rst_n_d  = alu_rst_n_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;
    timer_d      = timer_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        // Releases the ALU reset on the first edge after reset_n deasserts.
        alu_rst_n_d = 1'b1;
        start_d     = 1'b0;
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
          a_d      = head_a;
          b_d      = head_b;
          op_d     = head_op_norm;
          timer_d  = '0;
          if (head_op_norm == rst_op) begin
            state_d     = RST;
            alu_rst_n_d = 1'b0;
          end else if (is_alu_op(head_op_norm)) begin
            state_d = BUSY;
            start_d = 1'b1;
          end else begin
            state_d = NOP;
            start_d = 1'b1;
          end
        end
      end

      BUSY: begin
        // done wins over a timeout falling on the same edge.
        if (done) begin
          start_d      = 1'b0;
          rsp_result_d = result;
          rsp_err_d    = 1'b0;
          rsp_op_d     = op_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          start_d      = 1'b0;
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_op_d     = op_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      NOP: begin
        start_d      = 1'b0;
        rsp_result_d = '0;
        rsp_err_d    = 1'b0;
        rsp_op_d     = op_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end

      RST: begin
        // alu_rst_n already low for the entry cycle; hold it one more.
        if (timer_q == '0) begin
          timer_d = TW'(1);
        end else begin
          alu_rst_n_d  = 1'b1;
          rsp_result_d = '0;
          rsp_err_d    = 1'b0;
          rsp_op_d     = op_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        start_d     = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= no_op;
      start_q      <= 1'b0;
      alu_rst_n_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= no_op;
      rsp_err_q    <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      start_q      <= start_d;
      alu_rst_n_q  <= alu_rst_n_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
      timer_q      <= timer_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign op         = op_q;
  assign start      = start_q;
  assign alu_rst_n  = alu_rst_n_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Drives commands into alu_cmd_sequencer with a behavioural ALU attached and
//   compares every response against a command-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef struct packed {
    logic [15:0] result;
    logic [2:0]  op;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done = 1'b0;
  logic [15:0] result = '0;
  logic        alu_rst_n;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural ALU: done after alu_lat cycles of start (0 = never).
  int alu_lat = 1;
  bit noise = 1'b0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .A          (A),
    .B          (B),
    .op         (op),
    .start      (start),
    .done       (done),
    .result     (result),
    .alu_rst_n  (alu_rst_n),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .fifo_count (fifo_count)
  );

  function automatic logic [15:0] alu_calc(input logic [7:0] a, b, input logic [2:0] o);
    case (o)
      OP_ADD:  return {8'h00, a} + {8'h00, b};
      OP_AND:  return {8'h00, a & b};
      OP_XOR:  return {8'h00, a ^ b};
      OP_MUL:  return 16'(a) * 16'(b);
      default: return 16'hA5A5;
    endcase
  endfunction

  always @(negedge clk) begin
    if (start) begin
      start_cnt = start_cnt + 1;
      if (alu_lat != 0 && start_cnt == alu_lat) begin
        done   = 1'b1;
        result = alu_calc(A, B, op);
      end else begin
        done   = 1'b0;
        result = 16'($urandom);
      end
    end else begin
      start_cnt = 0;
      if (noise) begin
        done   = 1'($urandom_range(0, 1));
        result = 16'($urandom);
      end else begin
        done   = 1'b0;
        result = '0;
      end
    end
  end

  // Reference model: what a command should produce, given the ALU latency.
  function automatic rsp_t model_rsp(input logic [7:0] a, b, input logic [2:0] code, input int lat);
    rsp_t r;
    logic [2:0] k;
    k = (code == 3'b101 || code == 3'b110) ? OP_NOP : code;
    r.op = k;
    r.err = 1'b0;
    r.result = '0;
    if (k == OP_ADD || k == OP_AND || k == OP_XOR || k == OP_MUL) begin
      if (lat < 1 || lat > TIMEOUT) begin
        r.err = 1'b1;
      end else begin
        case (k)
          OP_ADD:  r.result = a + b;
          OP_AND:  r.result = a & b;
          OP_XOR:  r.result = a ^ b;
          default: r.result = a * b;
        endcase
      end
    end
    return r;
  endfunction

  // Offer one command starting at a negedge; returns at a negedge after acceptance.
  task automatic push_cmd(input logic [7:0] a, b, input logic [2:0] o, output bit ok);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = o;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for a response, capture it and complete the handshake.
  task automatic wait_rsp(output rsp_t r, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 400) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    r = {rsp_result, rsp_op, rsp_err};
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    noise = 1'b0;
    alu_lat = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++;
    if (fifo_count !== '0) begin n_errors++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    n_checks++;
    if ({start, rsp_valid, rsp_err} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags: start/rsp_valid/rsp_err got %b want 000", {start, rsp_valid, rsp_err});
    end
    n_checks++;
    if (alu_rst_n !== 1'b0) begin n_errors++; $display("FAIL reset_alu_rst_n: got %b want 0", alu_rst_n); end
    n_checks++;
    if ({A, B, op, rsp_result, rsp_op} !== '0) begin
      n_errors++; $display("FAIL reset_data: A=%h B=%h op=%h rsp_result=%h rsp_op=%h want all 0", A, B, op, rsp_result, rsp_op);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (alu_rst_n !== 1'b1) begin n_errors++; $display("FAIL reset_release_alu_rst_n: got %b want 1", alu_rst_n); end
    $display("test_reset: done");
  endtask

  task automatic test_add();
    bit ok, got;
    int hi;
    alu_lat = 1;
    hi = 0;
    got = 1'b0;
    push_cmd(8'h05, 8'h03, OP_ADD, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (start) hi++;
      if (rsp_valid) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got || !ok) begin n_errors++; $display("FAIL add_response: got rsp_valid=%b accepted=%b want 1/1", got, ok); end
    n_checks++;
    if (hi != 1) begin n_errors++; $display("FAIL add_start_cycles: got %0d want 1", hi); end
    n_checks++;
    if ({rsp_result, rsp_op, rsp_err} !== {16'h0008, OP_ADD, 1'b0}) begin
      n_errors++; $display("FAIL add_rsp: got result=%h op=%b err=%b want 0008/001/0", rsp_result, rsp_op, rsp_err);
    end
    n_checks++;
    if ({A, B, op} !== {8'h05, 8'h03, OP_ADD}) begin
      n_errors++; $display("FAIL add_alu_drive: got A=%h B=%h op=%b want 05/03/001", A, B, op);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL add_rsp_drop: rsp_valid got %b want 0", rsp_valid); end
    $display("test_add: result=%h", rsp_result);
  endtask

  task automatic test_mul();
    rsp_t r;
    bit ok, ok2;
    int hi;
    alu_lat = 3;
    hi = 0;
    push_cmd(8'hFF, 8'hFF, OP_MUL, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (start) hi++;
      if (rsp_valid) break;
    end
    wait_rsp(r, ok2);
    n_checks++;
    if (hi != 3) begin n_errors++; $display("FAIL mul_start_cycles: got %0d want 3", hi); end
    n_checks++;
    if (!ok || !ok2 || r !== {16'hFE01, OP_MUL, 1'b0}) begin
      n_errors++; $display("FAIL mul_rsp: got result=%h op=%b err=%b want fe01/100/0", r.result, r.op, r.err);
    end
    $display("test_mul: result=%h", r.result);
  endtask

  task automatic test_timeout();
    rsp_t r;
    bit ok, ok2;
    int hi;
    alu_lat = 0;
    hi = 0;
    push_cmd(8'h3C, 8'h5A, OP_XOR, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (start) hi++;
      if (rsp_valid) break;
    end
    wait_rsp(r, ok2);
    n_checks++;
    if (hi != TIMEOUT) begin n_errors++; $display("FAIL timeout_start_cycles: got %0d want %0d", hi, TIMEOUT); end
    n_checks++;
    if (!ok || !ok2 || r !== {16'h0000, OP_XOR, 1'b1}) begin
      n_errors++; $display("FAIL timeout_rsp: got result=%h op=%b err=%b want 0000/011/1", r.result, r.op, r.err);
    end
    $display("test_timeout: start high %0d cycles", hi);
  endtask

  task automatic test_rst_op();
    rsp_t r;
    bit ok, ok2, extra;
    int lo, hi;
    alu_lat = 1;
    lo = 0;
    hi = 0;
    extra = 1'b0;
    push_cmd(8'h12, 8'h34, OP_RST, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!alu_rst_n) lo++;
      if (start) hi++;
      if (rsp_valid) break;
    end
    wait_rsp(r, ok2);
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) extra = 1'b1;
    end
    n_checks++;
    if (lo != 2 || hi != 0) begin n_errors++; $display("FAIL rst_op_pulse: alu_rst_n low %0d start high %0d want 2/0", lo, hi); end
    n_checks++;
    if (!ok || !ok2 || r !== {16'h0000, OP_RST, 1'b0}) begin
      n_errors++; $display("FAIL rst_op_rsp: got result=%h op=%b err=%b want 0000/111/0", r.result, r.op, r.err);
    end
    n_checks++;
    if (extra) begin n_errors++; $display("FAIL rst_op_single_rsp: got extra rsp_valid want none"); end
    $display("test_rst_op: alu_rst_n low %0d cycles", lo);
  endtask

  task automatic test_nop_codes();
    logic [2:0] codes [3];
    rsp_t r;
    bit ok, ok2;
    int hi;
    codes[0] = 3'b000;
    codes[1] = 3'b101;
    codes[2] = 3'b110;
    alu_lat = 1; // done lands during NOP and must be ignored
    for (int k = 0; k < 3; k++) begin
      hi = 0;
      push_cmd(8'hAA, 8'h55, codes[k], ok);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (start) hi++;
        if (rsp_valid) break;
      end
      wait_rsp(r, ok2);
      n_checks++;
      if (hi != 1) begin n_errors++; $display("FAIL nop_start_cycles code=%b: got %0d want 1", codes[k], hi); end
      n_checks++;
      if (!ok || !ok2 || r !== {16'h0000, OP_NOP, 1'b0}) begin
        n_errors++; $display("FAIL nop_rsp code=%b: got result=%h op=%b err=%b want 0000/000/0", codes[k], r.result, r.op, r.err);
      end
      $display("test_nop_codes: code=%b rsp_op=%b", codes[k], r.op);
    end
  endtask

  task automatic test_fifo_full();
    rsp_t exp_q[$];
    rsp_t r, e;
    logic [7:0] a, b;
    logic [2:0] ops [5];
    bit ok, ok2, held;
    ops[0] = OP_ADD; ops[1] = OP_AND; ops[2] = OP_XOR; ops[3] = OP_MUL; ops[4] = OP_ADD;
    alu_lat = 2;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp_q.push_back(model_rsp(a, b, ops[i], alu_lat));
      push_cmd(a, b, ops[i], ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL fifo_full_accept %0d: cmd_ready stayed 0", i); end
    end
    n_checks++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
      n_errors++; $display("FAIL fifo_full_state: fifo_count=%0d cmd_ready=%b want 4/0", fifo_count, cmd_ready);
    end
    // Sixth command must be refused while full.
    held = 1'b1;
    cmd_valid = 1'b1;
    cmd_a = 8'h99;
    cmd_b = 8'h66;
    cmd_op = OP_ADD;
    repeat (4) begin
      @(negedge clk);
      if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) held = 1'b0;
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (!held) begin n_errors++; $display("FAIL fifo_full_hold: fifo_count=%0d cmd_ready=%b want 4/0", fifo_count, cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      wait_rsp(r, ok2);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok2 || r !== e) begin
        n_errors++; $display("FAIL fifo_order %0d: got %h/%b/%b want %h/%b/%b", i, r.result, r.op, r.err, e.result, e.op, e.err);
      end
      $display("test_fifo_full: rsp %0d op=%b result=%h", i, r.op, r.result);
    end
  endtask

  task automatic test_back_to_back(input int lat);
    rsp_t exp_q[$];
    alu_lat = lat;
    fork
      begin
        logic [7:0] a, b;
        logic [2:0] o;
        bit ok;
        for (int i = 0; i < 8; i++) begin
          a = 8'($urandom);
          b = 8'($urandom);
          o = 3'($urandom_range(0, 7));
          exp_q.push_back(model_rsp(a, b, o, lat));
          push_cmd(a, b, o, ok);
          n_checks++;
          if (!ok) begin n_errors++; $display("FAIL b2b_accept lat=%0d idx=%0d: never accepted", lat, i); end
        end
      end
      begin
        rsp_t r, e;
        bit ok;
        for (int i = 0; i < 8; i++) begin
          wait_rsp(r, ok);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          n_checks++;
          if (!ok || r !== e) begin
            n_errors++; $display("FAIL b2b_rsp lat=%0d idx=%0d: got %h/%b/%b want %h/%b/%b", lat, i, r.result, r.op, r.err, e.result, e.op, e.err);
          end
          $display("test_back_to_back: lat=%0d idx=%0d op=%b result=%h err=%b", lat, i, r.op, r.result, r.err);
        end
      end
    join
  endtask

  task automatic test_random();
    rsp_t e, first;
    logic [7:0] a, b;
    logic [2:0] o;
    bit ok, got, stable;
    int lat, d;
    noise = 1'b1;
    for (int it = 0; it < 30; it++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      o = 3'($urandom_range(0, 7));
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 3));
      alu_lat = lat;
      e = model_rsp(a, b, o, lat);
      push_cmd(a, b, o, ok);
      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
        if (rsp_valid) begin got = 1'b1; break; end
        @(negedge clk);
      end
      first = {rsp_result, rsp_op, rsp_err};
      stable = 1'b1;
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || {rsp_result, rsp_op, rsp_err} !== first) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_checks++;
      if (!ok || !got) begin n_errors++; $display("FAIL rand_handshake %0d: accepted=%b rsp_valid=%b want 1/1", it, ok, got); end
      n_checks++;
      if (!stable) begin n_errors++; $display("FAIL rand_stable %0d: rsp changed before rsp_ready", it); end
      n_checks++;
      if (first !== e) begin
        n_errors++; $display("FAIL rand_rsp %0d: got %h/%b/%b want %h/%b/%b", it, first.result, first.op, first.err, e.result, e.op, e.err);
      end
      $display("test_random: %0d a=%h b=%h code=%b lat=%0d result=%h err=%b", it, a, b, o, lat, first.result, first.err);
    end
    noise = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    bit ok0, ok1, ok2, quiet;
    alu_lat = 0;
    rsp_ready = 1'b0;
    push_cmd(8'h0F, 8'hF0, OP_XOR, ok0);
    push_cmd(8'h01, 8'h02, OP_ADD, ok1);
    push_cmd(8'h03, 8'h04, OP_AND, ok2);
    n_checks++;
    if (!(ok0 && ok1 && ok2) || start !== 1'b1 || fifo_count !== 3'd2) begin
      n_errors++; $display("FAIL midrst_setup: start=%b fifo_count=%0d want 1/2", start, fifo_count);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (start !== 1'b0 || fifo_count !== '0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL midrst_immediate: start=%b fifo_count=%0d cmd_ready=%b rsp_valid=%b want 0/0/1/0", start, fifo_count, cmd_ready, rsp_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || start !== 1'b0 || fifo_count !== '0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin n_errors++; $display("FAIL midrst_quiet: activity after reset rsp_valid=%b start=%b fifo_count=%0d", rsp_valid, start, fifo_count); end
    n_checks++;
    if (alu_rst_n !== 1'b1) begin n_errors++; $display("FAIL midrst_alu_rst_n: got %b want 1", alu_rst_n); end
    $display("test_reset_mid_busy: done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_timeout();
    test_rst_op();
    test_nop_codes();
    test_fifo_full();
    test_back_to_back(1);
    test_back_to_back(4);
    test_random();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: operand width; result is 2*WIDTH bits.
REQ-002 Parameter DEPTH, default 4: command FIFO entries, power of two, minimum 2.
REQ-003 Parameter TIMEOUT, default 15: maximum BUSY cycles waiting for done, minimum 1.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  FIFO can accept; high when count < DEPTH, no same-cycle pop bypass.
REQ-008 cmd_a, cmd_b  in  WIDTH  operands.
REQ-009 cmd_op  in  3  operation_t code.
REQ-010 A, B  out  WIDTH  registered operands to ALU.
REQ-011 op  out  3  registered operation to ALU.
REQ-012 start  out  1  ALU start, registered.
REQ-013 done  in  1  ALU completion.
REQ-014 result  in  2*WIDTH  ALU result.
REQ-015 alu_rst_n  out  1  ALU reset, active-low, registered.
REQ-016 rsp_valid / rsp_ready  out / in  1 each  response handshake.
REQ-017 rsp_result  out  2*WIDTH  captured result.
REQ-018 rsp_op  out  3  op of the completed command.
REQ-019 rsp_err  out  1  command timed out.
REQ-020 fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-021 Command accepted on posedge when cmd_valid && cmd_ready; FIFO preserves order.
REQ-022 States: IDLE, BUSY, NOP, RST, RESP.
REQ-023 IDLE, FIFO non-empty: pop head at the edge; load A/B/op; add/and/xor/mul -> BUSY with start=1; no_op -> NOP with start=1; rst_op -> RST with alu_rst_n=0, start=0.
REQ-024 Pop in IDLE occurs at the edge after the push into an empty FIFO (one-cycle minimum accept-to-start).
REQ-025 BUSY: start held 1; done sampled 1 at an edge -> capture result into rsp_result, rsp_err=0, start=0, -> RESP.
REQ-026 BUSY: cycle counter starts at 0 on entry; if TIMEOUT edges pass without done -> start=0, rsp_result=0, rsp_err=1, -> RESP.
REQ-027 done and result in any state other than BUSY are ignored.
REQ-028 NOP: start high exactly one cycle; next edge start=0, rsp_result=0, rsp_err=0, -> RESP.
REQ-029 RST: alu_rst_n low exactly two cycles, then 1; rsp_result=0, rsp_err=0, -> RESP.
REQ-030 RESP: rsp_valid=1, rsp_* stable until rsp_ready sampled 1; then rsp_valid=0, -> IDLE.
REQ-031 Undefined op codes (101, 110) are handled as no_op.
REQ-032 Push and pop in the same edge: count unchanged, both take effect.
REQ-033 FIFO pointers wrap modulo DEPTH.

Reset
REQ-034 reset_n low: state IDLE, FIFO empty, fifo_count=0, cmd_ready=1, start=0, alu_rst_n=0, rsp_valid=0, rsp_err=0, A/B/op/rsp_result/rsp_op=0.
REQ-035 Reset mid-operation discards the in-flight command and all queued commands; no response issued.
REQ-036 alu_rst_n returns to 1 at the first edge after reset_n deasserts.

Structure
REQ-037 operation_t (no_op=000, add_op=001, and_op=010, xor_op=011, mul_op=100, rst_op=111) and the sequencer state enum reside in tinyalu_pkg.
REQ-038 The FIFO is a separate sub-module alu_cmd_fifo, parametrised by WIDTH and DEPTH.

Verification
REQ-039 add 8'h05+8'h03, done after 1 cycle, result 8 -> rsp_result=16'h0008, rsp_op=add_op, rsp_err=0.
REQ-040 mul 8'hFF*8'hFF, done after 3 cycles -> start high 3 cycles, rsp_result=16'hFE01.
REQ-041 rsp_ready held 0, push 5 commands, DEPTH=4 -> cmd_ready low after 4 queued, commands complete in order.
REQ-042 xor command, done never asserted, TIMEOUT=15 -> start drops after 15 cycles, rsp_err=1, rsp_result=0.
REQ-043 rst_op -> alu_rst_n low exactly 2 cycles, start stays 0, one response with rsp_op=rst_op.
REQ-044 reset_n pulsed low during BUSY with 2 queued -> start=0 immediately, fifo_count=0, no rsp_valid afterwards.
